test_value_uart_tx: RTL



---
 rtl/mips_uart_pkg.sv | 16 +
 rtl/uart_tx_byte.sv | 96 +++++++++
 rtl/test_value_uart_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_uart_pkg.sv
// Shared definitions for the test_value UART transmitter: FSM encoding, frame
// constants and the nibble-to-ASCII helper used by the optional hex mode.
package mips_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int         UART_FRAME_BITS = 10;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_LF        = 8'h0A;

    // Upper-case hex digit: '0'..'9' then 'A'..'F'.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: baud counter, START/DATA/STOP sequencing and the tx flop.
// byte_ready is also high in the last STOP cycle so frames can chain with no gap.
module uart_tx_byte
    import mips_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    // Data bits are the frame minus start and stop; index of the last one.
    localparam logic [2:0]      LAST_BIT = 3'(UART_FRAME_BITS - 3);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             cnt_last;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can infer a latch.
        cnt_last   = (cnt_q == LAST_CNT);
        byte_ready = (state_q == IDLE) || ((state_q == STOP) && cnt_last);
        state_d    = state_q;
        cnt_d      = cnt_last ? '0 : cnt_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
            START: begin
                if (cnt_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            STOP: begin
                if (cnt_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (byte_ready && byte_valid) begin
            state_d = START;
            cnt_d   = '0;
            tx_d    = 1'b0;
            shreg_d = byte_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/test_value_uart_tx.sv
// Streams every change of test_value (or a send_req) over UART, MSB byte first,
// with a one-word pending buffer and saturating overwrite counter.
// Define TEST_VALUE_TX_HEX_EN to send upper-case ASCII hex plus CR LF instead of raw bytes.
module test_value_uart_tx
    import mips_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] test_value,
    input  logic                  send_req,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            ovf_cnt
);

`ifdef TEST_VALUE_TX_HEX_EN
    localparam int FRAMES = DATA_WIDTH / 4 + 2;
    localparam int SHIFT  = 4;
`else
    localparam int FRAMES = DATA_WIDTH / 8;
    localparam int SHIFT  = 8;
`endif
    localparam int               REM_W    = $clog2(FRAMES + 1);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(FRAMES - 1);

    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic [7:0]            ovf_q, ovf_d;

    logic                  event_hit, start_ok, mid_word, load_new;
    logic [DATA_WIDTH-1:0] src_word;
    logic                  byte_valid, byte_ready;
    logic [7:0]            byte_data;

    always_comb begin
        event_hit = (test_value != prev_q) | send_req;
        // rem_q counts frames of the current word not yet started.
        start_ok  = !busy_q || (byte_ready && (rem_q == '0));
        mid_word  = busy_q && byte_ready && (rem_q != '0);

        prev_d       = test_value;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ovf_d        = ovf_q;
        busy_d       = busy_q;
        word_d       = word_q;
        rem_d        = rem_q;
        load_new     = 1'b0;
        src_word     = word_q;

        if (start_ok) begin
            // A waiting word goes first; a simultaneous event takes its slot.
            if (pend_valid_q) begin
                load_new     = 1'b1;
                src_word     = pend_q;
                pend_valid_d = event_hit;
                if (event_hit) pend_d = test_value;
            end else if (event_hit) begin
                load_new = 1'b1;
                src_word = test_value;
            end
            busy_d = load_new;
        end else if (event_hit) begin
            pend_d       = test_value;
            pend_valid_d = 1'b1;
            if (pend_valid_q && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
        end

        byte_valid = load_new | mid_word;
        if (byte_valid) begin
            word_d = src_word << SHIFT;
            rem_d  = load_new ? REM_LOAD : rem_q - 1'b1;
        end

`ifdef TEST_VALUE_TX_HEX_EN
        if (!load_new && (rem_q == REM_W'(2)))      byte_data = ASCII_CR;
        else if (!load_new && (rem_q == REM_W'(1))) byte_data = ASCII_LF;
        else                                        byte_data = hex_char(src_word[DATA_WIDTH-1 -: 4]);
`else
        byte_data = src_word[DATA_WIDTH-1 -: 8];
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            word_q       <= '0;
            rem_q        <= '0;
            busy_q       <= 1'b0;
            ovf_q        <= '0;
        end else begin
            prev_q       <= prev_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            word_q       <= word_d;
            rem_q        <= rem_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .CLK       (CLK),
        .RESET     (RESET),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .tx        (tx)
    );

    assign busy    = busy_q;
    assign ovf_cnt = ovf_q;

endmodule
